// File: rtl/bitcol_scheduler.sv
// Control stage for the bit-serial MAC: splits a 16x8 weight tile into non-zero bit-columns
// (MSB first), emits registered mux/mode controls per column, then one drain cycle and tile_done.
module bitcol_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_in,
  input  logic                                  stall,
  output logic                                  mac_en,
  output logic                                  load_accum,
  output logic [7:0][SEL_WIDTH-1:0]             act_sel,
  output logic [7:0]                            act_val,
  output logic [1:0]                            is_skip_zero,
  output logic [2:0]                            column_idx,
  output logic                                  is_msb,
  output logic                                  en_mul,
  output logic                                  mul_const,
  output logic [1:0]                            shift_mul_sel,
  output logic                                  busy,
  output logic                                  tile_done
);

  localparam int LW = $clog2(VEC_LENGTH);
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                                state_q;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] wt_q;
  logic [DATA_WIDTH-1:0]                 rem_q;
  logic                                  mac_en_q, load_q, msb_q, done_q;
  logic [7:0][SEL_WIDTH-1:0]             sel_q;
  logic [7:0]                            val_q;
  logic [1:0]                            sz_q;
  logic [2:0]                            col_q;

  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] src;
  logic [DATA_WIDTH-1:0]                 nz, avail, rem_d;
  logic [2:0]                            col_d;
  logic [7:0][SEL_WIDTH-1:0]             sel_d;
  logic [7:0]                            val_d;
  logic [1:0]                            sz_d;
  logic [7:0]                            gbits;
  logic [3:0]                            pc;
  logic                                  want;
  int unsigned                           tk;

  // In IDLE the first column is encoded straight from w_in so it can be registered at the handshake edge.
  always_comb begin
    src   = (state_q == IDLE) ? w_in : wt_q;
    nz    = '0;
    for (int unsigned l = 0; l < VEC_LENGTH; l++) nz = nz | w_in[LW'(l)];
    avail = (state_q == IDLE) ? nz : rem_q;
    col_d = '0;
    for (int unsigned c = 0; c < DATA_WIDTH; c++)
      if (avail[CW'(c)]) col_d = 3'(c);
    rem_d = avail;
    rem_d[CW'(col_d)] = 1'b0;
    sel_d = '0;
    val_d = '0;
    sz_d  = '1;
    gbits = '0;
    pc    = '0;
    want  = 1'b1;
    tk    = 0;
    for (int unsigned g = 0; g < 2; g++) begin
      pc = '0;
      for (int unsigned j = 0; j < 8; j++) begin
        gbits[3'(j)] = src[LW'(8*g+j)][CW'(col_d)];
        pc = pc + 4'(gbits[3'(j)]);
      end
      // Encode whichever polarity is sparser: ones when pc<=4, otherwise the (<=3) zeros.
      want = (pc <= 4'd4);
      sz_d[1'(g)] = want;
      tk = 0;
      for (int unsigned p = 0; p < 8; p++) begin
        if (gbits[3'(p)] == want && tk < 4) begin
          sel_d[3'(4*g+tk)] = SEL_WIDTH'(p - tk);
          val_d[3'(4*g+tk)] = 1'b1;
          tk = tk + 1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wt_q     <= '0;
      rem_q    <= '0;
      mac_en_q <= 1'b0;
      load_q   <= 1'b0;
      sel_q    <= '0;
      val_q    <= '0;
      sz_q     <= '1;
      col_q    <= '0;
      msb_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (!stall) begin
      case (state_q)
        IDLE: begin
          if (w_valid) begin
            state_q  <= ISSUE;
            wt_q     <= w_in;
            rem_q    <= rem_d;
            mac_en_q <= 1'b1;
            load_q   <= 1'b1;
            sel_q    <= sel_d;
            val_q    <= val_d;
            sz_q     <= sz_d;
            col_q    <= col_d;
            msb_q    <= (col_d == 3'(DATA_WIDTH-1));
          end
        end
        ISSUE: begin
          load_q <= 1'b0;
          if (rem_q == '0) begin
            state_q <= DRAIN;
            sel_q   <= '0;
            val_q   <= '0;
            sz_q    <= '1;
            col_q   <= '0;
            msb_q   <= 1'b0;
          end else begin
            rem_q <= rem_d;
            sel_q <= sel_d;
            val_q <= val_d;
            sz_q  <= sz_d;
            col_q <= col_d;
            msb_q <= (col_d == 3'(DATA_WIDTH-1));
          end
        end
        DRAIN: begin
          state_q  <= DONE;
          mac_en_q <= 1'b0;
          done_q   <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall gates the enable-type outputs immediately; everything else simply holds.
  assign w_ready       = (state_q == IDLE) && !stall;
  assign mac_en        = mac_en_q && !stall;
  assign tile_done     = done_q && !stall;
  assign busy          = (state_q != IDLE);
  assign load_accum    = load_q;
  assign act_sel       = sel_q;
  assign act_val       = val_q;
  assign is_skip_zero  = sz_q;
  assign column_idx    = col_q;
  assign is_msb        = msb_q;
  assign en_mul        = 1'b0;
  assign mul_const     = 1'b0;
  assign shift_mul_sel = 2'b00;

endmodule

// File: tb/tb_bitcol_scheduler.sv
// Self-checking bench for bitcol_scheduler: directed and random tiles against a column-list reference model.
module tb_bitcol_scheduler;

  typedef logic [15:0][7:0] tile_t;
  typedef struct packed {
    logic           mac_en;
    logic           load;
    logic [7:0][2:0] sel;
    logic [7:0]     val;
    logic [1:0]     sz;
    logic [2:0]     col;
    logic           msb;
    logic           done;
  } rec_t;

  logic            clk, reset, w_valid, w_ready, stall;
  tile_t           w_in;
  logic            mac_en, load_accum, is_msb, en_mul, mul_const, busy, tile_done;
  logic [7:0][2:0] act_sel;
  logic [7:0]      act_val;
  logic [1:0]      is_skip_zero, shift_mul_sel;
  logic [2:0]      column_idx;

  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];
  rec_t first_rec;
  rec_t rst_rec;
  int   done_cyc;

  bitcol_scheduler #(.DATA_WIDTH(8), .VEC_LENGTH(16), .SEL_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready), .w_in(w_in),
    .stall(stall), .mac_en(mac_en), .load_accum(load_accum), .act_sel(act_sel),
    .act_val(act_val), .is_skip_zero(is_skip_zero), .column_idx(column_idx),
    .is_msb(is_msb), .en_mul(en_mul), .mul_const(mul_const),
    .shift_mul_sel(shift_mul_sel), .busy(busy), .tile_done(tile_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic rec_t observe();
    rec_t o;
    o.mac_en = mac_en;  o.load = load_accum; o.sel = act_sel; o.val = act_val;
    o.sz = is_skip_zero; o.col = column_idx; o.msb = is_msb; o.done = tile_done;
    return o;
  endfunction

  // Reference: list of non-zero columns high to low, each encoded from sorted target positions.
  task automatic build_model(input tile_t t, output int n);
    int   cols[$];
    int   ones[$];
    int   zeros[$];
    int   tg[$];
    rec_t r;
    bit   any;
    exp_q.delete();
    for (int c = 7; c >= 0; c--) begin
      any = 0;
      for (int l = 0; l < 16; l++) any |= t[l][c];
      if (any) cols.push_back(c);
    end
    if (cols.size() == 0) begin
      r = '0; r.mac_en = 1; r.load = 1; r.sz = 2'b11;
      exp_q.push_back(r);
    end
    foreach (cols[i]) begin
      r = '0; r.mac_en = 1; r.load = (i == 0);
      r.col = 3'(cols[i]); r.msb = (cols[i] == 7);
      for (int g = 0; g < 2; g++) begin
        ones.delete(); zeros.delete();
        for (int j = 0; j < 8; j++)
          if (t[8*g+j][cols[i]]) ones.push_back(j); else zeros.push_back(j);
        if (ones.size() <= 4) begin tg = ones; r.sz[g] = 1'b1; end
        else begin tg = zeros; r.sz[g] = 1'b0; end
        foreach (tg[k]) begin
          r.sel[4*g+k] = 3'(tg[k] - k);
          r.val[4*g+k] = 1'b1;
        end
      end
      exp_q.push_back(r);
    end
    r = '0; r.mac_en = 1; r.sz = 2'b11;
    exp_q.push_back(r);
    r.mac_en = 0; r.done = 1;
    exp_q.push_back(r);
    n = (cols.size() == 0) ? 1 : cols.size();
  endtask

  // Entered and left at posedge+1.
  task automatic run_tile(input tile_t t, input int stall_at, input int stall_len,
                          input int reset_at, input bit idle_stall);
    int   n, idx, nst;
    bit   st, aborted;
    rec_t e;
    build_model(t, n);
    idx = 0; nst = 0; aborted = 0; done_cyc = -1;
    w_valid = 1; w_in = t;
    if (idle_stall) begin
      stall = 1;
      @(negedge clk);
      chk("idle_stall_ready", w_ready, 0);
      @(posedge clk); #1;
      stall = 0;
    end
    @(negedge clk);
    chk("ready_before", w_ready, 1);
    @(posedge clk); #1;
    w_valid = 0; w_in = tile_t'({$urandom, $urandom, $urandom, $urandom});
    for (int cyc = 1; idx < exp_q.size() && cyc < 100; cyc++) begin
      st = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      stall = st;
      reset = (cyc == reset_at);
      @(negedge clk);
      e = exp_q[idx];
      if (st) begin e.mac_en = 0; e.done = 0; end
      chk($sformatf("rec_c%0d", cyc), 64'(observe()), 64'(e));
      chk("ready_busy", {w_ready, busy}, 2'b01);
      if (cyc == 1) first_rec = observe();
      if (tile_done === 1'b1) done_cyc = cyc;
      @(posedge clk); #1;
      if (cyc == reset_at) begin reset = 0; aborted = 1; break; end
      if (st) nst++; else idx++;
    end
    stall = 0;
    if (aborted) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("post_reset_rec", 64'(observe()), 64'(rst_rec));
        chk("post_reset_ready_busy", {w_ready, busy}, 2'b10);
        @(posedge clk); #1;
      end
    end else begin
      chk("done_cycle", 64'(done_cyc), 64'(n + 2 + nst));
      @(negedge clk);
      chk("idle_after", {w_ready, busy, tile_done}, 3'b100);
      chk("mul_path", {en_mul, mul_const, shift_mul_sel}, 4'b0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tile_t t;
    rst_rec = '0; rst_rec.sz = 2'b11;
    reset = 1; w_valid = 0; stall = 0; w_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset_rec", 64'(observe()), 64'(rst_rec));
    chk("reset_ready_busy", {w_ready, busy}, 2'b10);
    chk("reset_mul", {en_mul, mul_const, shift_mul_sel}, 4'b0);
    @(posedge clk); #1;

    for (int l = 0; l < 16; l++) t[l] = 8'h01;
    run_tile(t, 0, 0, 0, 0);
    chk("ones01_done", 64'(done_cyc), 64'(3));
    chk("ones01_first", {first_rec.col, first_rec.sz, first_rec.val, first_rec.load}, {3'd0, 2'b00, 8'h00, 1'b1});

    t = '0; t[0] = 8'h80;
    run_tile(t, 0, 0, 0, 0);
    chk("msb_done", 64'(done_cyc), 64'(3));
    chk("msb_first", {first_rec.col, first_rec.msb, first_rec.sel[0], first_rec.val, first_rec.sz},
        {3'd7, 1'b1, 3'd0, 8'h01, 2'b11});

    t = '0; t[3] = 8'h80; t[5] = 8'h80; t[6] = 8'h80; t[7] = 8'h80;
    run_tile(t, 0, 0, 0, 0);
    chk("ones3567", {first_rec.sel[3:0], first_rec.val, first_rec.sz}, {3'd4, 3'd4, 3'd4, 3'd3, 8'h0F, 2'b11});

    t = '0; t[0] = 8'h80; t[2] = 8'h80; t[3] = 8'h80; t[5] = 8'h80; t[6] = 8'h80; t[7] = 8'h80;
    run_tile(t, 0, 0, 0, 0);
    chk("zeros14", {first_rec.sel[1:0], first_rec.val, first_rec.sz}, {3'd3, 3'd1, 8'h03, 2'b10});

    t = '0;
    run_tile(t, 0, 0, 0, 0);
    chk("allzero_done", 64'(done_cyc), 64'(3));

    for (int l = 0; l < 16; l++) t[l] = 8'hFF;
    run_tile(t, 0, 0, 0, 0);
    chk("ff_done", 64'(done_cyc), 64'(10));
    run_tile(t, 4, 2, 0, 0);
    chk("ff_stall_done", 64'(done_cyc), 64'(12));
    run_tile(t, 0, 0, 4, 0);
    chk("ff_reset_nodone", 64'(done_cyc), 64'(-1));

    for (int i = 0; i < 30; i++) begin
      logic [7:0] cm;
      cm = 8'($urandom) & 8'($urandom);
      for (int l = 0; l < 16; l++)
        t[l] = cm & (($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      run_tile(t, $urandom_range(1, 6), $urandom_range(0, 3), 0, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
